// File: rtl/csr_exec_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_exec_if
//  Description : Bundle of dispatch, common-data-bus, flush and result
//                signals between the CSR execution unit and its environment.
//                master : drives dispatch / CDB / flush, receives results
//                slave  : the CSR execution unit itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_exec_if;

    // Dispatch channel
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic [1:0]  dispatch_op;
    logic [11:0] dispatch_csr_addr;
    logic [31:0] dispatch_csr_old;
    logic        dispatch_rs1_ready;
    logic [5:0]  dispatch_rs1_tag;
    logic [31:0] dispatch_rs1_value;
    logic [5:0]  dispatch_rd_tag;

    // Common data bus broadcast
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_value;

    // Exception kill
    logic        flush;

    // CSR register-file write request
    logic        CSR_done;
    logic [31:0] CSR_Result;
    logic [11:0] RS_CSR_Address;

    // Old CSR value written back to rd
    logic        rd_valid;
    logic [5:0]  rd_tag;
    logic [31:0] rd_value;

    // Buffer fill level
    logic [2:0]  occupancy;

    modport master (
        output dispatch_valid, dispatch_op, dispatch_csr_addr, dispatch_csr_old,
               dispatch_rs1_ready, dispatch_rs1_tag, dispatch_rs1_value,
               dispatch_rd_tag, cdb_valid, cdb_tag, cdb_value, flush,
        input  dispatch_ready, CSR_done, CSR_Result, RS_CSR_Address,
               rd_valid, rd_tag, rd_value, occupancy
    );

    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_csr_addr, dispatch_csr_old,
               dispatch_rs1_ready, dispatch_rs1_tag, dispatch_rs1_value,
               dispatch_rd_tag, cdb_valid, cdb_tag, cdb_value, flush,
        output dispatch_ready, CSR_done, CSR_Result, RS_CSR_Address,
               rd_valid, rd_tag, rd_value, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/csr_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : csr_exec_unit
//  Description : In-order CSR execution buffer. Four-entry circular FIFO of
//                dispatched CSR instructions; entries wait for their rs1
//                operand on the CDB, the head entry issues once ready and
//                its result / old value are presented one cycle later.
//  Ports       : clk   - clock, all state on rising edge
//                reset - synchronous, active-high
//                bus   - csr_exec_if.slave (dispatch, CDB, flush, results,
//                        occupancy)
//  Options     : CSR_EXEC_FWD_EN - when defined, an issuing result is
//                forwarded into the old value of younger same-address
//                entries (and a same-cycle dispatch to that address).
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_exec_unit (
    input  wire        clk,
    input  wire        reset,
    csr_exec_if.slave  bus
);

    localparam int         c_DEPTH = 4;
    localparam logic [1:0] c_OP_RO = 2'b00;
    localparam logic [1:0] c_OP_RW = 2'b01;
    localparam logic [1:0] c_OP_RS = 2'b10;
    localparam logic [1:0] c_OP_RC = 2'b11;

    // Entry control state
    logic [c_DEPTH-1:0] r_vld;
    logic [c_DEPTH-1:0] r_rdy;
    logic [1:0]         r_head;
    logic [1:0]         r_tail;
    logic [2:0]         r_count;

    // Entry payload
    logic [1:0]  r_op      [c_DEPTH];
    logic [11:0] r_addr    [c_DEPTH];
    logic [31:0] r_old     [c_DEPTH];
    logic [5:0]  r_src_tag [c_DEPTH];
    logic [31:0] r_src     [c_DEPTH];
    logic [5:0]  r_rd_tag  [c_DEPTH];

    // Registered outputs
    logic        r_done;
    logic [31:0] r_result;
    logic [11:0] r_res_addr;
    logic [5:0]  r_out_tag;
    logic [31:0] r_out_old;

    logic        w_ready;
    logic        w_alloc;
    logic        w_issue;
    logic [31:0] w_result;
    logic        w_new_rdy;
    logic [31:0] w_new_src;
    logic [31:0] w_new_old;

    // Full buffer refuses dispatch even if the head leaves this cycle.
    assign w_ready = (r_count < 3'd4);
    assign w_alloc = bus.dispatch_valid && w_ready && !bus.flush;
    assign w_issue = r_vld[r_head] && r_rdy[r_head] && !bus.flush;

    always_comb begin
        w_result = r_old[r_head];
        case (r_op[r_head])
            c_OP_RW: w_result = r_src[r_head];
            c_OP_RS: w_result = r_old[r_head] | r_src[r_head];
            c_OP_RC: w_result = r_old[r_head] & ~r_src[r_head];
            c_OP_RO: w_result = r_old[r_head];
            default: w_result = r_old[r_head];
        endcase
    end

    // A dispatching entry whose operand is broadcast in the same cycle
    // enters the buffer already awake.
    always_comb begin
        w_new_rdy = bus.dispatch_rs1_ready;
        w_new_src = bus.dispatch_rs1_value;
        if (!bus.dispatch_rs1_ready && bus.cdb_valid &&
            (bus.cdb_tag == bus.dispatch_rs1_tag)) begin
            w_new_rdy = 1'b1;
            w_new_src = bus.cdb_value;
        end
    end

`ifdef CSR_EXEC_FWD_EN
    assign w_new_old = (w_issue && (bus.dispatch_csr_addr == r_addr[r_head])) ?
                       w_result : bus.dispatch_csr_old;
`else
    assign w_new_old = bus.dispatch_csr_old;
`endif

    // Control state: reset dominates flush, flush dominates everything else.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_vld   <= '0;
            r_rdy   <= '0;
            r_head  <= 2'd0;
            r_tail  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (r_vld[i] && !r_rdy[i] && bus.cdb_valid &&
                    (bus.cdb_tag == r_src_tag[i])) begin
                    r_rdy[i] <= 1'b1;
                end
            end
            if (w_issue) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 2'd1;
            end
            // The tail slot is never valid while allocating, so this cannot
            // collide with the head clear above.
            if (w_alloc) begin
                r_vld[r_tail] <= 1'b1;
                r_rdy[r_tail] <= w_new_rdy;
                r_tail        <= r_tail + 2'd1;
            end
            case ({w_alloc, w_issue})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload carries no reset: contents of invalid slots are never used.
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_DEPTH; i++) begin
            if (r_vld[i] && !r_rdy[i] && bus.cdb_valid &&
                (bus.cdb_tag == r_src_tag[i])) begin
                r_src[i] <= bus.cdb_value;
            end
`ifdef CSR_EXEC_FWD_EN
            // Every other valid entry is younger than the head.
            if (w_issue && r_vld[i] && (2'(i) != r_head) &&
                (r_addr[i] == r_addr[r_head])) begin
                r_old[i] <= w_result;
            end
`endif
        end
        if (w_alloc) begin
            r_op[r_tail]      <= bus.dispatch_op;
            r_addr[r_tail]    <= bus.dispatch_csr_addr;
            r_old[r_tail]     <= w_new_old;
            r_src_tag[r_tail] <= bus.dispatch_rs1_tag;
            r_src[r_tail]     <= w_new_src;
            r_rd_tag[r_tail]  <= bus.dispatch_rd_tag;
        end
    end

    // Result stage: done is a one-cycle pulse, data holds between issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done     <= 1'b0;
            r_result   <= '0;
            r_res_addr <= '0;
            r_out_tag  <= '0;
            r_out_old  <= '0;
        end else begin
            r_done <= w_issue;
            if (w_issue) begin
                r_result   <= w_result;
                r_res_addr <= r_addr[r_head];
                r_out_tag  <= r_rd_tag[r_head];
                r_out_old  <= r_old[r_head];
            end
        end
    end

    assign bus.dispatch_ready = w_ready;
    assign bus.occupancy      = r_count;
    assign bus.CSR_done       = r_done;
    assign bus.CSR_Result     = r_result;
    assign bus.RS_CSR_Address = r_res_addr;
    assign bus.rd_valid       = r_done;
    assign bus.rd_tag         = r_out_tag;
    assign bus.rd_value       = r_out_old;

endmodule
`default_nettype wire

// File: doc/csr_exec_unit.md
CSR_EXEC_UNIT -- requirements
Module: csr_exec_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port dispatch_valid, input, 1 bit: a CSR instruction is presented for dispatch.
REQ-004 SHALL have port dispatch_ready, output, 1 bit: the buffer can accept an entry; equals (occupancy < 4).
REQ-005 SHALL have port dispatch_op, input, 2 bits: 00 read-only, 01 RW, 10 RS (set), 11 RC (clear).
REQ-006 SHALL have ports dispatch_csr_addr (input, 12 bits) and dispatch_csr_old (input, 32 bits): target CSR address and the CSR value read at ID.
REQ-007 SHALL have ports dispatch_rs1_ready (input, 1), dispatch_rs1_tag (input, 6) and dispatch_rs1_value (input, 32): source operand state.
REQ-008 SHALL have port dispatch_rd_tag, input, 6 bits: destination physical tag.
REQ-009 SHALL have ports cdb_valid (input, 1), cdb_tag (input, 6) and cdb_value (input, 32): common data bus broadcast.
REQ-010 SHALL have port flush, input, 1 bit: the exception signal; kills all entries.
REQ-011 SHALL have ports CSR_done (output, 1), CSR_Result (output, 32) and RS_CSR_Address (output, 12): the CSR write request to the CSR register file.
REQ-012 SHALL have ports rd_valid (output, 1), rd_tag (output, 6) and rd_value (output, 32): old CSR value written back to rd.
REQ-013 SHALL have port occupancy, output, 3 bits: number of valid entries (0-4).

Function
REQ-014 SHALL hold a 4-entry circular FIFO with 2-bit head/tail pointers wrapping 3->0.
REQ-015 SHALL allocate at tail when dispatch_valid && dispatch_ready; dispatch while full SHALL be ignored with no state change, including when an issue occurs in the same cycle.
REQ-016 SHALL set an entry's operand ready when a cdb_valid broadcast matches the tag of a waiting entry; a same-cycle CDB match on a dispatching entry SHALL capture cdb_value.
REQ-017 SHALL issue only the head entry, in order, at most one per cycle, and only once its operand is ready; younger ready entries SHALL wait.
REQ-018 SHALL compute the result as: RW = src; RS = old | src; RC = old & ~src; read-only = old.
REQ-019 SHALL register outputs with 1-cycle latency: the cycle after issue, CSR_done=1, CSR_Result=result, RS_CSR_Address=addr, rd_valid=1, rd_tag=tag, rd_value=old; all are single-cycle pulses, otherwise done/valid are 0 and data holds.
REQ-020 SHALL update occupancy as +1 on dispatch, -1 on issue, and unchanged on both in the same cycle.
REQ-021 On flush, all entries SHALL be invalidated, pointers and occupancy zeroed, and no issue produced; flush SHALL take priority over dispatch, wakeup and issue in that cycle, and outputs from an earlier-cycle issue are still emitted.

Reset
REQ-022 On reset, all entries SHALL be invalidated, pointers zeroed, occupancy=0, and CSR_done, rd_valid, CSR_Result, RS_CSR_Address, rd_tag and rd_value all 0.
REQ-023 Reset mid-operation SHALL discard pending entries with no CSR_done in the following cycle; reset SHALL dominate flush.

Configuration
REQ-024 With CSR_EXEC_FWD_EN defined, on issue every younger valid entry with the same CSR address SHALL have its old value replaced by the issued result, and a same-cycle dispatch to that address SHALL capture the issued result.
REQ-025 Without CSR_EXEC_FWD_EN, old values SHALL remain as dispatched and software serializes same-address CSR ops.

Verification
REQ-026 Dispatch RS, addr 0x000, old 0x0000_00F0, rs1 ready 0x0000_000F -> next cycle issue; following cycle CSR_done=1, CSR_Result=0x0000_00FF, rd_value=0x0000_00F0.
REQ-027 Dispatch RC with rs1 tag 5 not ready; two cycles later cdb tag 5 value 0x0000_0001 with old 0x0000_0003 -> CSR_Result=0x0000_0002 two cycles after the broadcast.
REQ-028 Fill 4 entries (head waiting) -> dispatch_ready=0 and a 5th dispatch dropped; wakeup head -> 4 pulses on consecutive cycles in order, pointers wrap, occupancy returns to 0.
REQ-029 Two RW to addr 0x002 (src 0xA then 0xB, old 0x0) -> with FWD: second rd_value=0xA; without FWD: second rd_value=0x0.
REQ-030 3 entries pending, assert flush together with a dispatch -> occupancy=0, no CSR_done afterwards, dispatch_ready=1.
